i_cache_nway: RTL and testbench
===============================

# i_cache_nway

Parametrised N-way set-associative instruction cache with multi-word lines, uncached-segment bypass and whole-cache invalidate. It sits between the core's instruction SRAM-like port (`cpu_inst_*`) and the AXI bridge's instruction SRAM-like port (`cache_inst_*`). It is a drop-in replacement for the single-configuration instruction cache inside the cache top: same port names and handshake, generalised in ways, sets and line length.

## Interface
Parameters:
- `WAYS`, 2, associativity; legal values are 1, 2 and 4.
- `SETS`, 64, sets per way; power of two, ≥2.
- `LINE_WORDS`, 4, 32-bit words per line; power of two, ≥1.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `inv`  in  1  level; requests invalidation of every line.
- `cpu_inst_req`, `cpu_inst_wr`, `cpu_inst_size[1:0]`, `cpu_inst_addr[31:0]`, `cpu_inst_wdata[31:0]`  in  core request. `wr`, `size` and `wdata` are ignored; the port is read-only.
- `cpu_inst_rdata`  out  32  read data; valid only while `cpu_inst_data_ok` is high.
- `cpu_inst_addr_ok`, `cpu_inst_data_ok`  out  1  core handshakes.
- `cache_inst_req`  out  1  memory read request.
- `cache_inst_wr`  out  1  constant 0.
- `cache_inst_size`  out  2  constant 2'b10.
- `cache_inst_wdata`  out  32  constant 0.
- `cache_inst_addr`  out  32  word-aligned memory address.
- `cache_inst_rdata`  in  32  memory read data.
- `cache_inst_addr_ok`, `cache_inst_data_ok`  in  1  memory handshakes.

## Operation
- Address split: `[1:0]` byte; `OFF=log2(LINE_WORDS)` bits word select; `IDX=log2(SETS)` bits set index; remaining upper bits are the tag.
- Storage: tag and data arrays per way, synchronous read. Valid bits are flops (WAYS×SETS). Per-set round-robin pointer, log2(WAYS) bits.
- FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, UNC_REQ, UNC_WAIT, RESP.
- IDLE:
  - `cpu_inst_addr_ok=1` unless `inv` or a pending invalidate is set.
  - On accept (`req&addr_ok`): latch the address and start the array read.
  - `addr[31:29]==3'b101` goes to UNC_REQ; otherwise to LOOKUP.
- LOOKUP: compare tags across all valid ways.
  - Hit: `cpu_inst_data_ok=1` with the selected word; go to IDLE.
  - Miss: choose the victim and go to MISS_REQ.
- Victim selection: lowest-numbered invalid way; if all ways are valid, the way at the pointer. The pointer increments (wrapping) on every fill of that set. WAYS=1 always selects way 0.
- MISS_REQ:
  - Drive `cache_inst_req=1` with `addr = {tag,idx,cnt,2'b00}`. `cnt` starts at 0 (line base).
  - On `cache_inst_addr_ok`, go to MISS_WAIT.
- MISS_WAIT:
  - On `cache_inst_data_ok`, write the word into the victim way at `cnt`. Capture it if `cnt` equals the requested word.
  - If `cnt==LINE_WORDS-1`: write the tag, set valid, advance the pointer, go to RESP. Otherwise increment `cnt` and go to MISS_REQ.
- UNC_REQ / UNC_WAIT: a single read of the latched address, unchanged. No allocation. The data is captured, then go to RESP.
- RESP: `cpu_inst_data_ok=1` with the captured word; go to IDLE.
- Invalidate:
  - `inv` seen in IDLE clears all valid bits on the next edge; pointers are unchanged.
  - `inv` seen in any other state sets a pending flag, applied on the first IDLE cycle. No request is accepted in that cycle.
- Exactly one outstanding memory request at a time. `cache_inst_data_ok` is ignored outside MISS_WAIT/UNC_WAIT.

## Timing
- Reset values:
  - All outputs are 0 except `cache_inst_size=2'b10`.
  - FSM in IDLE; all valid bits, pointers, `cnt` and the pending flag are 0.
  - `cpu_inst_addr_ok` goes to 1 on the first cycle after reset release.
- Hit: accept at cycle T, `cpu_inst_data_ok` at T+1. Maximum throughput is one hit per 2 cycles.
- Miss: first `cache_inst_req` at T+2. `cpu_inst_data_ok` comes one cycle after the last memory `data_ok`.
- While `cache_inst_req=1` and `addr_ok=0`, `cache_inst_addr` holds stable.
- Reset asserted mid-refill: the FSM aborts immediately and the partial line is never marked valid.

## Structure
- Package `i_cache_pkg`:
  - FSM state enum.
  - Constants `KSEG1_HI=3'b101` and word size.
  - Width helpers for OFF, IDX and tag derived from the parameters.
- Sub-module `cache_sram_1r1w` (parametrised width/depth, synchronous read, one write port). Instantiated once per way for tags and once per way for data, with the data array at depth SETS×LINE_WORDS.
- Valid bits, pointers, FSM and counters live in the top.

## Test plan
Defaults throughout (WAYS=2, SETS=64, LINE_WORDS=4): the index is `addr[9:4]` and the tag is `addr[31:10]`.
- **Cold miss:** read 0x0000_0104 → memory reads 0x100, 0x104, 0x108, 0x10C in order; CPU receives the 0x104 word one cycle after the 4th `data_ok`. Re-reading 0x0000_0108 → `data_ok` at T+1 with no `cache_inst_req`.
- **Replacement:** fill 0x0100, then 0x0500 (set 16, ways 0 and 1), then 0x0900 → way 0 (pointer) is evicted. 0x0500 still hits; 0x0100 misses.
- **Uncached:** read 0xBFC0_0000 → exactly one memory read at 0xBFC0_0000. Repeating it issues another read; a kseg0 alias read afterwards still misses.
- **Invalidate:** after a hit on 0x0104, pulse `inv` in IDLE → `addr_ok` is 0 for that cycle; the next read of 0x0104 misses and refetches 4 words.
- **Stall:** hold `cache_inst_addr_ok=0` for 3 cycles on word 1 → `req` and `addr` stay stable; the final data is correct.
- **Reset mid-refill:** assert `rst` low after 2 of 4 words → outputs return to reset values; the same read afterwards refetches all 4 words.

Source files
------------

// File: rtl/i_cache_pkg.sv
// ----------------------------------------------------------------------------
// i_cache_pkg
// Shared definitions for the N-way instruction cache:
//   - FSM state encoding
//   - address-map and bus constants
//   - width helpers that derive field widths from the cache geometry
// ----------------------------------------------------------------------------
package i_cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_MISS_REQ  = 3'd2,
        S_MISS_WAIT = 3'd3,
        S_UNC_REQ   = 3'd4,
        S_UNC_WAIT  = 3'd5,
        S_RESP      = 3'd6
    } state_e;

    // Upper three address bits that identify the uncached kseg1 segment.
    localparam logic [2:0] KSEG1_HI      = 3'b101;
    localparam int         WORD_BYTES    = 4;
    localparam int         BYTE_OFF_W    = 2;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    // Width of a counter/pointer over n items, never narrower than one bit.
    function automatic int width_min1(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    // Word-select field width inside a line (zero for one-word lines).
    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Set-index field width.
    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    // Tag field width: whatever remains above index, word select and byte.
    function automatic int tag_w(input int sets, input int line_words);
        return 32 - BYTE_OFF_W - off_w(line_words) - idx_w(sets);
    endfunction

endpackage

// File: rtl/i_cache_nway_sram.sv
// ----------------------------------------------------------------------------
// cache_sram_1r1w
// Simple dual-port storage array: one synchronous read port, one write port.
// Read data appears on the cycle after re is sampled high and then holds
// until the next read.
//   clk    in   clock
//   re     in   read enable
//   raddr  in   read address  [AW]
//   rdata  out  read data     [WIDTH]
//   we     in   write enable
//   waddr  in   write address [AW]
//   wdata  in   write data    [WIDTH]
// ----------------------------------------------------------------------------
module cache_sram_1r1w #(
    parameter int WIDTH = 32,
    parameter int AW    = 6,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port; output holds between reads.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/i_cache_nway.sv
// ----------------------------------------------------------------------------
// i_cache_nway
// N-way set-associative, read-only instruction cache with multi-word lines,
// kseg1 uncached bypass and whole-cache invalidate.
// Ports:
//   clk, rst (async active-low), inv (level invalidate request)
//   cpu_inst_*   core-side SRAM-like port (req/addr in, rdata/addr_ok/data_ok out;
//                wr/size/wdata are ignored)
//   cache_inst_* memory-side SRAM-like port (req/addr out, wr=0, size=word,
//                wdata=0; rdata/addr_ok/data_ok in)
// ----------------------------------------------------------------------------
module i_cache_nway
    import i_cache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inv,
    input  logic        cpu_inst_req,
    input  logic        cpu_inst_wr,
    input  logic [1:0]  cpu_inst_size,
    input  logic [31:0] cpu_inst_addr,
    input  logic [31:0] cpu_inst_wdata,
    output logic [31:0] cpu_inst_rdata,
    output logic        cpu_inst_addr_ok,
    output logic        cpu_inst_data_ok,
    output logic        cache_inst_req,
    output logic        cache_inst_wr,
    output logic [1:0]  cache_inst_size,
    output logic [31:0] cache_inst_addr,
    output logic [31:0] cache_inst_wdata,
    input  logic [31:0] cache_inst_rdata,
    input  logic        cache_inst_addr_ok,
    input  logic        cache_inst_data_ok
);

    localparam int OFF_W   = off_w(LINE_WORDS);
    localparam int IDX_W   = idx_w(SETS);
    localparam int TAG_W   = tag_w(SETS, LINE_WORDS);
    localparam int TAG_LSB = BYTE_OFF_W + OFF_W + IDX_W;
    localparam int CNT_W   = width_min1(LINE_WORDS);
    localparam int PTR_W   = width_min1(WAYS);
    localparam int DAW     = IDX_W + OFF_W;

    localparam logic [31:0]      LINE_MASK = 32'(LINE_WORDS * WORD_BYTES - 1);
    localparam logic [31:0]      WSEL_MASK = 32'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(WAYS - 1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  victim_q, victim_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              pend_q, pend_d;
    logic              rdy_q;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [PTR_W-1:0]  ptr_q   [SETS];

    // ------------------------------------------------------------------
    // Address fields
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  idx_in_s, idx_q_s;
    logic [DAW-1:0]    daddr_in_s, daddr_fill_s;
    logic [TAG_W-1:0]  tag_q_s;
    logic [CNT_W-1:0]  req_off_s;
    logic [31:0]       miss_addr_s;

    assign idx_in_s     = cpu_inst_addr[TAG_LSB-1 -: IDX_W];
    assign daddr_in_s   = cpu_inst_addr[TAG_LSB-1 -: DAW];
    assign idx_q_s      = addr_q[TAG_LSB-1 -: IDX_W];
    assign tag_q_s      = addr_q[31 -: TAG_W];
    assign req_off_s    = CNT_W'((addr_q >> 5'd2) & WSEL_MASK);
    assign daddr_fill_s = DAW'((32'(idx_q_s) << OFF_W) | 32'(cnt_q));
    // Refill walks the line from its base word regardless of the requested word.
    assign miss_addr_s  = (addr_q & ~LINE_MASK) | (32'(cnt_q) << 5'd2);

    // ------------------------------------------------------------------
    // Storage arrays
    // ------------------------------------------------------------------
    logic              accept_s;
    logic              fill_we_s;
    logic              fill_last_s;
    logic              inv_apply_s;
    logic [WAYS-1:0]   data_we_s;
    logic [WAYS-1:0]   tag_we_s;
    logic [TAG_W-1:0]  tag_rd_s  [WAYS];
    logic [31:0]       data_rd_s [WAYS];

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        assign data_we_s[g] = fill_we_s && (victim_q == PTR_W'(g));
        assign tag_we_s[g]  = fill_we_s && fill_last_s && (victim_q == PTR_W'(g));

        cache_sram_1r1w #(
            .WIDTH (TAG_W),
            .AW    (IDX_W),
            .DEPTH (SETS)
        ) u_tag (
            .clk   (clk),
            .re    (accept_s),
            .raddr (idx_in_s),
            .rdata (tag_rd_s[g]),
            .we    (tag_we_s[g]),
            .waddr (idx_q_s),
            .wdata (tag_q_s)
        );

        cache_sram_1r1w #(
            .WIDTH (32),
            .AW    (DAW),
            .DEPTH (SETS * LINE_WORDS)
        ) u_data (
            .clk   (clk),
            .re    (accept_s),
            .raddr (daddr_in_s),
            .rdata (data_rd_s[g]),
            .we    (data_we_s[g]),
            .waddr (daddr_fill_s),
            .wdata (cache_inst_rdata)
        );
    end

    // ------------------------------------------------------------------
    // Hit detection and victim choice
    // ------------------------------------------------------------------
    logic              hit_s;
    logic [31:0]       hit_word_s;
    logic [PTR_W-1:0]  victim_s;

    // Tag compare across valid ways; the lowest matching way supplies the word.
    always_comb begin
        hit_s      = 1'b0;
        hit_word_s = 32'd0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_s && valid_q[idx_q_s][w] && (tag_rd_s[w] == tag_q_s)) begin
                hit_s      = 1'b1;
                hit_word_s = data_rd_s[w];
            end else begin
                hit_word_s = hit_word_s;
            end
        end
    end

    // Victim: lowest invalid way, else the set's round-robin pointer.
    always_comb begin
        victim_s = ptr_q[idx_q_s];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx_q_s][w]) begin
                victim_s = PTR_W'(w);
            end else begin
                victim_s = victim_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    logic        addr_ok_s;
    logic        data_ok_s;
    logic [31:0] cpu_rdata_s;
    logic        mreq_s;
    logic [31:0] maddr_s;

    // Next-state, handshake and fill-control decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        victim_d    = victim_q;
        rdata_d     = rdata_q;
        // An invalidate arriving mid-transaction is remembered for the next IDLE.
        pend_d      = pend_q | (inv && (state_q != S_IDLE));
        accept_s    = 1'b0;
        inv_apply_s = 1'b0;
        fill_we_s   = 1'b0;
        fill_last_s = 1'b0;
        addr_ok_s   = 1'b0;
        data_ok_s   = 1'b0;
        cpu_rdata_s = 32'd0;
        mreq_s      = 1'b0;
        maddr_s     = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (inv || pend_q) begin
                    inv_apply_s = 1'b1;
                    pend_d      = 1'b0;
                end else if (rdy_q) begin
                    addr_ok_s = 1'b1;
                    if (cpu_inst_req) begin
                        accept_s = 1'b1;
                        addr_d   = cpu_inst_addr;
                        cnt_d    = '0;
                        if (cpu_inst_addr[31:29] == KSEG1_HI) begin
                            state_d = S_UNC_REQ;
                        end else begin
                            state_d = S_LOOKUP;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOOKUP: begin
                if (hit_s) begin
                    data_ok_s   = 1'b1;
                    cpu_rdata_s = hit_word_s;
                    state_d     = S_IDLE;
                end else begin
                    victim_d = victim_s;
                    cnt_d    = '0;
                    state_d  = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                mreq_s  = 1'b1;
                maddr_s = miss_addr_s;
                if (cache_inst_addr_ok) begin
                    state_d = S_MISS_WAIT;
                end else begin
                    state_d = S_MISS_REQ;
                end
            end
            S_MISS_WAIT: begin
                if (cache_inst_data_ok) begin
                    fill_we_s = 1'b1;
                    if (cnt_q == req_off_s) begin
                        rdata_d = cache_inst_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    if (cnt_q == CNT_LAST) begin
                        fill_last_s = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = S_MISS_REQ;
                    end
                end else begin
                    state_d = S_MISS_WAIT;
                end
            end
            S_UNC_REQ: begin
                mreq_s  = 1'b1;
                maddr_s = addr_q;
                if (cache_inst_addr_ok) begin
                    state_d = S_UNC_WAIT;
                end else begin
                    state_d = S_UNC_REQ;
                end
            end
            S_UNC_WAIT: begin
                if (cache_inst_data_ok) begin
                    rdata_d = cache_inst_rdata;
                    state_d = S_RESP;
                end else begin
                    state_d = S_UNC_WAIT;
                end
            end
            S_RESP: begin
                data_ok_s   = 1'b1;
                cpu_rdata_s = rdata_q;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and transaction registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            cnt_q    <= '0;
            victim_q <= '0;
            rdata_q  <= 32'd0;
            pend_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            victim_q <= victim_d;
            rdata_q  <= rdata_d;
            pend_q   <= pend_d;
            rdy_q    <= 1'b1;
        end
    end

    // Valid bits and per-set replacement pointers; a line becomes valid only
    // once its last word has landed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (inv_apply_s) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else if (fill_we_s && fill_last_s) begin
            valid_q[idx_q_s][victim_q] <= 1'b1;
            if (ptr_q[idx_q_s] == PTR_LAST) begin
                ptr_q[idx_q_s] <= '0;
            end else begin
                ptr_q[idx_q_s] <= ptr_q[idx_q_s] + PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cpu_inst_addr_ok = addr_ok_s;
    assign cpu_inst_data_ok = data_ok_s;
    assign cpu_inst_rdata   = cpu_rdata_s;
    assign cache_inst_req   = mreq_s;
    assign cache_inst_addr  = maddr_s;
    assign cache_inst_wr    = 1'b0;
    assign cache_inst_size  = MEM_SIZE_WORD;
    assign cache_inst_wdata = 32'd0;

    // The core port is read-only; write-side fields are deliberately dropped.
    logic unused_inputs_s;
    assign unused_inputs_s = ^{cpu_inst_wr, cpu_inst_size, cpu_inst_wdata};

endmodule

// File: tb/tb_i_cache_nway.sv
module tb_i_cache_nway;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inv = 1'b0;
    logic        cpu_inst_req = 1'b0;
    logic        cpu_inst_wr = 1'b0;
    logic [1:0]  cpu_inst_size = 2'b10;
    logic [31:0] cpu_inst_addr = 32'd0;
    logic [31:0] cpu_inst_wdata = 32'd0;
    logic [31:0] cpu_inst_rdata;
    logic        cpu_inst_addr_ok;
    logic        cpu_inst_data_ok;
    logic        cache_inst_req;
    logic        cache_inst_wr;
    logic [1:0]  cache_inst_size;
    logic [31:0] cache_inst_addr;
    logic [31:0] cache_inst_wdata;
    logic [31:0] cache_inst_rdata = 32'd0;
    logic        cache_inst_addr_ok = 1'b0;
    logic        cache_inst_data_ok = 1'b0;

    i_cache_nway #(.WAYS(2), .SETS(64), .LINE_WORDS(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .inv                (inv),
        .cpu_inst_req       (cpu_inst_req),
        .cpu_inst_wr        (cpu_inst_wr),
        .cpu_inst_size      (cpu_inst_size),
        .cpu_inst_addr      (cpu_inst_addr),
        .cpu_inst_wdata     (cpu_inst_wdata),
        .cpu_inst_rdata     (cpu_inst_rdata),
        .cpu_inst_addr_ok   (cpu_inst_addr_ok),
        .cpu_inst_data_ok   (cpu_inst_data_ok),
        .cache_inst_req     (cache_inst_req),
        .cache_inst_wr      (cache_inst_wr),
        .cache_inst_size    (cache_inst_size),
        .cache_inst_addr    (cache_inst_addr),
        .cache_inst_wdata   (cache_inst_wdata),
        .cache_inst_rdata   (cache_inst_rdata),
        .cache_inst_addr_ok (cache_inst_addr_ok),
        .cache_inst_data_ok (cache_inst_data_ok)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0] mem_log[$];
    int          mem_first_req_cyc = -1;
    int          mem_last_dok_cyc  = 0;
    int          mem_dok_cnt       = 0;
    bit          rsp_pend          = 1'b0;
    logic [31:0] rsp_addr          = 32'd0;
    int          stall_idx         = -1;
    int          stall_left        = 0;
    bit          stall_active      = 1'b0;
    logic [31:0] stall_addr        = 32'd0;

    initial begin
        forever begin
            @(negedge clk);
            cache_inst_addr_ok = 1'b0;
            cache_inst_data_ok = 1'b0;
            cache_inst_rdata   = 32'h0BAD_0BAD;
            if (!rst) begin
                rsp_pend     = 1'b0;
                stall_active = 1'b0;
            end else begin
                if (stall_active) begin
                    check("stall_req_held", 32'(cache_inst_req), 32'd1);
                    check("stall_addr_held", cache_inst_addr, stall_addr);
                end
                if (rsp_pend) begin
                    cache_inst_data_ok = 1'b1;
                    cache_inst_rdata   = mem_word(rsp_addr);
                    rsp_pend           = 1'b0;
                    mem_last_dok_cyc   = cyc;
                    mem_dok_cnt++;
                end else if (cache_inst_req) begin
                    if (mem_first_req_cyc < 0) mem_first_req_cyc = cyc;
                    if ((mem_log.size() == stall_idx) && (stall_left > 0)) begin
                        if (!stall_active) begin
                            stall_active = 1'b1;
                            stall_addr   = cache_inst_addr;
                        end
                        stall_left--;
                    end else begin
                        stall_active       = 1'b0;
                        cache_inst_addr_ok = 1'b1;
                        mem_log.push_back(cache_inst_addr);
                        rsp_pend = 1'b1;
                        rsp_addr = cache_inst_addr;
                    end
                end
            end
        end
    end

    // ---------------- CPU-side read ----------------
    task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                           output int lat, output int t1, output int resp_cyc);
        int guard;
        data = 32'd0; lat = 0; t1 = 0; resp_cyc = 0;
        mem_log.delete();
        mem_first_req_cyc = -1;
        @(negedge clk);
        cpu_inst_req  = 1'b1;
        cpu_inst_addr = a;
        #1;
        guard = 0;
        while (!cpu_inst_addr_ok && guard < 50) begin
            @(negedge clk); #1; guard++;
        end
        if (!cpu_inst_addr_ok) begin
            check("accept_timeout", 32'(cpu_inst_addr_ok), 32'd1);
            cpu_inst_req = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cpu_inst_req = 1'b0;
        t1 = cyc;
        #1;
        lat = 1;
        while (!cpu_inst_data_ok && lat < 200) begin
            @(negedge clk); #1; lat++;
        end
        check("resp_seen", 32'(cpu_inst_data_ok), 32'd1);
        data     = cpu_inst_rdata;
        resp_cyc = cyc;
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          hit;
        int          nreq;
        logic [31:0] first;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int lat, t1, rc, g;

        // addr, hit, memory reads, first memory address, word returned
        vecs[0]  = '{32'h0000_0104, 1'b0, 4, 32'h0000_0100, 32'h0000_0104};
        vecs[1]  = '{32'h0000_0108, 1'b1, 0, 32'h0000_0000, 32'h0000_0108};
        vecs[2]  = '{32'h0000_0100, 1'b1, 0, 32'h0000_0000, 32'h0000_0100};
        vecs[3]  = '{32'h0000_0500, 1'b0, 4, 32'h0000_0500, 32'h0000_0500};
        vecs[4]  = '{32'h0000_0900, 1'b0, 4, 32'h0000_0900, 32'h0000_0900};
        vecs[5]  = '{32'h0000_050C, 1'b1, 0, 32'h0000_0000, 32'h0000_050C};
        vecs[6]  = '{32'h0000_0104, 1'b0, 4, 32'h0000_0100, 32'h0000_0104};
        vecs[7]  = '{32'h0000_090C, 1'b1, 0, 32'h0000_0000, 32'h0000_090C};
        vecs[8]  = '{32'hBFC0_0000, 1'b0, 1, 32'hBFC0_0000, 32'hBFC0_0000};
        vecs[9]  = '{32'hBFC0_0000, 1'b0, 1, 32'hBFC0_0000, 32'hBFC0_0000};
        vecs[10] = '{32'h9FC0_0000, 1'b0, 4, 32'h9FC0_0000, 32'h9FC0_0000};
        vecs[11] = '{32'h9FC0_0004, 1'b1, 0, 32'h0000_0000, 32'h9FC0_0004};
        vecs[12] = '{32'h0000_010E, 1'b1, 0, 32'h0000_0000, 32'h0000_010C};

        // ---- reset values ----
        #2 rst = 1'b0;
        #10;
        check("rst_addr_ok",  32'(cpu_inst_addr_ok), 32'd0);
        check("rst_data_ok",  32'(cpu_inst_data_ok), 32'd0);
        check("rst_rdata",    cpu_inst_rdata, 32'd0);
        check("rst_mreq",     32'(cache_inst_req), 32'd0);
        check("rst_maddr",    cache_inst_addr, 32'd0);
        check("rst_mwr",      32'(cache_inst_wr), 32'd0);
        check("rst_msize",    32'(cache_inst_size), 32'd2);
        check("rst_mwdata",   cache_inst_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("addr_ok_before_edge", 32'(cpu_inst_addr_ok), 32'd0);
        @(negedge clk);
        #1 check("addr_ok_after_release", 32'(cpu_inst_addr_ok), 32'd1);

        // ---- table-driven reads ----
        for (int i = 0; i < 13; i++) begin
            do_read(vecs[i].addr, d, lat, t1, rc);
            check($sformatf("v%0d_data", i), d, mem_word(vecs[i].word));
            check($sformatf("v%0d_nreq", i), 32'(mem_log.size()), 32'(vecs[i].nreq));
            if (vecs[i].hit) begin
                check($sformatf("v%0d_hit_latency", i), 32'(lat), 32'd1);
            end else begin
                for (int k = 0; k < mem_log.size(); k++) begin
                    check($sformatf("v%0d_maddr%0d", i, k), mem_log[k], vecs[i].first + 32'(4 * k));
                end
                check($sformatf("v%0d_resp_after_last", i), 32'(rc - mem_last_dok_cyc), 32'd1);
                if (vecs[i].nreq == 4) begin
                    check($sformatf("v%0d_first_req_t2", i), 32'(mem_first_req_cyc), 32'(t1 + 1));
                end
            end
        end

        // ---- invalidate in IDLE ----
        do_read(32'h0000_0104, d, lat, t1, rc);
        check("inv_prehit_nreq", 32'(mem_log.size()), 32'd0);
        @(negedge clk);
        inv = 1'b1;
        #1 check("inv_blocks_addr_ok", 32'(cpu_inst_addr_ok), 32'd0);
        @(negedge clk);
        inv = 1'b0;
        #1 check("inv_release_addr_ok", 32'(cpu_inst_addr_ok), 32'd1);
        do_read(32'h0000_0104, d, lat, t1, rc);
        check("inv_refetch_nreq", 32'(mem_log.size()), 32'd4);
        check("inv_refetch_data", d, mem_word(32'h0000_0104));

        // ---- invalidate during a miss is deferred to IDLE ----
        mem_log.delete();
        @(negedge clk);
        cpu_inst_req  = 1'b1;
        cpu_inst_addr = 32'h0000_0604;
        #1 check("pend_accept", 32'(cpu_inst_addr_ok), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cpu_inst_req = 1'b0;
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        #1;
        g = 0;
        while (!cpu_inst_data_ok && g < 100) begin
            @(negedge clk); #1; g++;
        end
        check("pend_data", cpu_inst_rdata, mem_word(32'h0000_0604));
        @(negedge clk);
        #1 check("pend_blocks_addr_ok", 32'(cpu_inst_addr_ok), 32'd0);
        @(negedge clk);
        #1 check("pend_release_addr_ok", 32'(cpu_inst_addr_ok), 32'd1);
        do_read(32'h0000_0604, d, lat, t1, rc);
        check("pend_refetch_nreq", 32'(mem_log.size()), 32'd4);

        // ---- memory addr_ok stall on word 1 ----
        stall_idx  = 1;
        stall_left = 3;
        do_read(32'h0000_2004, d, lat, t1, rc);
        check("stall_data", d, mem_word(32'h0000_2004));
        check("stall_consumed", 32'(stall_left), 32'd0);
        check("stall_nreq", 32'(mem_log.size()), 32'd4);
        check("stall_word1_addr", mem_log[1], 32'h0000_2004);
        stall_idx = -1;

        // ---- reset in the middle of a refill ----
        mem_log.delete();
        mem_dok_cnt = 0;
        @(negedge clk);
        cpu_inst_req  = 1'b1;
        cpu_inst_addr = 32'h0000_3008;
        #1 check("rmid_accept", 32'(cpu_inst_addr_ok), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cpu_inst_req = 1'b0;
        #1;
        g = 0;
        while (mem_dok_cnt < 2 && g < 100) begin
            @(negedge clk); #1; g++;
        end
        check("rmid_two_words", 32'(mem_dok_cnt), 32'd2);
        rst = 1'b0;
        #1;
        check("rmid_addr_ok",  32'(cpu_inst_addr_ok), 32'd0);
        check("rmid_data_ok",  32'(cpu_inst_data_ok), 32'd0);
        check("rmid_mreq",     32'(cache_inst_req), 32'd0);
        check("rmid_maddr",    cache_inst_addr, 32'd0);
        check("rmid_msize",    32'(cache_inst_size), 32'd2);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        do_read(32'h0000_3008, d, lat, t1, rc);
        check("rmid_refetch_nreq", 32'(mem_log.size()), 32'd4);
        check("rmid_refetch_first", mem_log[0], 32'h0000_3000);
        check("rmid_refetch_data", d, mem_word(32'h0000_3008));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
